pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch stage of the 274 processor.
//  Holds the PC, issues one instruction-memory request at a time over a
//  req/ack handshake, and presents the fetched word to decode.
//  Consumes the branch-taken decision from and2gate (F = Branch & Zero)
//  plus the jump controls, and redirects the PC on either.
// PARAMETERS
//  ADDR_W    32          PC / memory address width (bits)
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  INC       4           PC increment per sequential fetch (bytes)
// PORTS
//  Clk           in   1       rising-edge clock
//  Rst_n         in   1       asynchronous reset, active low
//  BranchTaken   in   1       and2gate F output; redirect to BranchTarget
//  BranchTarget  in   ADDR_W  branch destination address
//  Jump          in   1       unconditional redirect to JumpTarget
//  JumpTarget    in   ADDR_W  jump destination address
//  Stall         in   1       decode cannot accept; hold delivered instr
//  IMemReq       out  1       fetch request to instruction memory
//  IMemAddr      out  ADDR_W  fetch address, stable while IMemReq=1
//  IMemAck       in   1       memory has returned IMemRdata this cycle
//  IMemRdata     in   32      instruction word, valid when IMemAck=1
//  InstrValid    out  1       Instr/InstrPC valid for decode
//  Instr         out  32      fetched instruction
//  InstrPC       out  ADDR_W  address Instr was fetched from
//  PC            out  ADDR_W  address of next fetch
// BEHAVIOUR
//  - Reset: Rst_n=0 forces immediately (async) state=BOOT, PC=RESET_PC,
//    IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instr=0, InstrPC=0,
//    redirect_pend=0. Mid-request reset abandons the request; any later ack ignored.
//  - All outputs registered; IMemAddr always equals PC.
//  - Redirect = BranchTaken | Jump. BranchTaken has priority over Jump.
//    Target low 2 bits forced to 0.
//  - FSM:
//    BOOT : first edge after reset release -> REQ (IMemReq=1 next cycle).
//    REQ  : IMemReq=1. Address must not change until IMemAck=1.
//           Redirect in REQ w/o ack: target stored in redirect_pend; stay REQ.
//           IMemAck=1, no redirect now/pending: Instr<=IMemRdata,
//             InstrPC<=PC, PC<=PC+INC, InstrValid<=1, IMemReq<=0 -> DELIV.
//           IMemAck=1 with redirect now or pending: data discarded,
//             PC<=target (current cycle's redirect wins over pending),
//             pend cleared, stay REQ (new request next cycle).
//    DELIV: InstrValid=1. Stall=1: hold Instr/InstrPC/PC, stay DELIV.
//           Stall=0, no redirect: instr consumed; InstrValid<=0, -> REQ.
//           Redirect (any Stall): instr squashed; InstrValid<=0,
//             PC<=target -> REQ.
//  - Decode consumes iff InstrValid & ~Stall & ~BranchTaken & ~Jump.
//  - Fetch latency: ack in cycle N -> InstrValid=1 in cycle N+1;
//    zero-wait memory gives one instruction per 2 cycles.
//  - PC arithmetic modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  - Ack while IMemReq=0 is ignored. No more than one request outstanding.
// TESTING
//  1 Reset, ack every REQ cycle, IMemRdata=addr^32'hA5 -> InstrPC 0,4,8,
//    InstrValid every 2nd cycle, Instr matches, IMemAddr=RESET_PC first.
//  2 Ack delayed 3 cycles -> IMemAddr/IMemReq stable all 3 cycles;
//    InstrValid only the cycle after ack.
//  3 BranchTaken=1, BranchTarget=32'h40 during DELIV of PC 8 -> instr
//    squashed, next IMemAddr=32'h40, next InstrPC=32'h40.
//  4 BranchTaken and Jump together (0x80 vs 0xC0) -> fetch from 0x80;
//    redirect during unacked REQ -> ack data dropped, next fetch at target.
//  5 Stall=1 for 4 cycles in DELIV -> Instr/InstrPC/PC unchanged, no
//    new IMemReq; Stall=0 -> REQ next cycle at PC+4.
//  6 PC=32'hFFFF_FFFC fetched -> next IMemAddr=0; Rst_n low mid-REQ ->
//    IMemReq=0 same cycle, PC=RESET_PC, late ack ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage.
// Keeps the PC and issues one instruction-memory request at a time over a
// req/ack handshake. Each fetched word is presented to decode with the
// address it came from. Branch and jump redirects move the PC. A redirect
// that arrives while a request is outstanding is stored until the ack
// arrives, so the address on the memory bus stays stable.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                INC      = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Stall,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [31:0]       IMemRdata,
    output logic              InstrValid,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic [ADDR_W-1:0] PC
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        DELIV = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic              redirect;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] target;

    // Select the redirect target (branch beats jump) and word-align it.
    always_comb begin
        redirect   = BranchTaken | Jump;
        target_raw = BranchTaken ? BranchTarget : JumpTarget;
        target     = {target_raw[ADDR_W-1:2], 2'b00};
    end

    // Compute the next state of the fetch FSM and all registered outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            BOOT: begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: begin
                if (IMemAck) begin
                    if (redirect) begin
                        // The returned word is on the wrong path. Refetch
                        // from this cycle's target.
                        pc_d   = target;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d    = IMemRdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + INC_V;
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = DELIV;
                    end
                end else if (redirect) begin
                    // The address must not move mid-request. Store the target
                    // and apply it when the ack arrives.
                    pend_d     = 1'b1;
                    pend_tgt_d = target;
                end
            end
            DELIV: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if (!Stall) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. An asynchronous reset abandons any request.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // The memory address is always the PC.
    always_comb begin
        IMemReq    = req_q;
        IMemAddr   = pc_q;
        InstrValid = valid_q;
        Instr      = instr_q;
        InstrPC    = instr_pc_q;
        PC         = pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_pc_fetch_unit;

    logic        Clk;
    logic        Rst_n;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] PC;

    int vectors;
    int miscompares;

    pc_fetch_unit dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Stall        (Stall),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemRdata    (IMemRdata),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .PC           (PC)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    // Start in REQ at addr. Ack with addr^A5 and check the delivered word.
    task automatic fetch_ok(input logic [31:0] addr);
        chk("req_before_ack", {31'd0, IMemReq}, 32'd1);
        chk("addr_before_ack", IMemAddr, addr);
        IMemAck   = 1'b1;
        IMemRdata = addr ^ 32'hA5;
        cyc();
        IMemAck   = 1'b0;
        IMemRdata = 32'h0;
        chk("deliv_valid", {31'd0, InstrValid}, 32'd1);
        chk("deliv_instr", Instr, addr ^ 32'hA5);
        chk("deliv_instrpc", InstrPC, addr);
        chk("deliv_pc", PC, addr + 32'd4);
        chk("deliv_req", {31'd0, IMemReq}, 32'd0);
        $display("fetch addr=%h instr=%h", addr, Instr);
    endtask

    // Start in DELIV. Let decode consume, then expect REQ at next_addr.
    task automatic consume(input logic [31:0] next_addr);
        cyc();
        chk("cons_valid", {31'd0, InstrValid}, 32'd0);
        chk("cons_req", {31'd0, IMemReq}, 32'd1);
        chk("cons_addr", IMemAddr, next_addr);
        $display("consume -> next addr=%h", IMemAddr);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Rst_n        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        Jump         = 1'b0;
        JumpTarget   = 32'h0;
        Stall        = 1'b0;
        IMemAck      = 1'b0;
        IMemRdata    = 32'h0;

        // Reset state
        #2;
        chk("rst_req", {31'd0, IMemReq}, 32'd0);
        chk("rst_addr", IMemAddr, 32'h0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_instrpc", InstrPC, 32'h0);
        chk("rst_pc", PC, 32'h0);
        $display("reset checked");
        cyc();
        Rst_n = 1'b1;
        cyc();

        // 1: zero-wait fetches from 0, 4, 8
        fetch_ok(32'h0);
        consume(32'h4);
        fetch_ok(32'h4);
        consume(32'h8);

        // 2: ack delayed 3 cycles, address held stable
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wait_req", {31'd0, IMemReq}, 32'd1);
            chk("wait_addr", IMemAddr, 32'h8);
            chk("wait_valid", {31'd0, InstrValid}, 32'd0);
            $display("wait cycle %0d addr=%h", i, IMemAddr);
        end
        fetch_ok(32'h8);

        // 3: branch during DELIV squashes the instruction
        BranchTaken  = 1'b1;
        BranchTarget = 32'h40;
        cyc();
        BranchTaken = 1'b0;
        chk("br_valid", {31'd0, InstrValid}, 32'd0);
        chk("br_req", {31'd0, IMemReq}, 32'd1);
        chk("br_addr", IMemAddr, 32'h40);
        $display("branch -> addr=%h", IMemAddr);
        fetch_ok(32'h40);
        consume(32'h44);

        // 4a: branch and jump together during an unacked REQ
        BranchTaken  = 1'b1;
        BranchTarget = 32'h80;
        Jump         = 1'b1;
        JumpTarget   = 32'hC0;
        cyc();
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        chk("pend_addr_stable", IMemAddr, 32'h44);
        chk("pend_req", {31'd0, IMemReq}, 32'd1);
        IMemAck   = 1'b1;
        IMemRdata = 32'hDEAD_BEEF;
        cyc();
        IMemAck = 1'b0;
        chk("pend_drop_valid", {31'd0, InstrValid}, 32'd0);
        chk("pend_redir_addr", IMemAddr, 32'h80);
        $display("pending redirect -> addr=%h", IMemAddr);

        // 4b: jump with ack in the same cycle, target low bits forced to 0
        Jump       = 1'b1;
        JumpTarget = 32'hC3;
        IMemAck    = 1'b1;
        IMemRdata  = 32'h1234_5678;
        cyc();
        Jump    = 1'b0;
        IMemAck = 1'b0;
        chk("jack_valid", {31'd0, InstrValid}, 32'd0);
        chk("jack_addr", IMemAddr, 32'hC0);
        $display("jump with ack -> addr=%h", IMemAddr);
        fetch_ok(32'hC0);

        // 5: stall four cycles in DELIV; a stray ack is ignored
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IMemAck   = (i == 1);
            IMemRdata = 32'hFFFF_0000;
            cyc();
            chk("stall_valid", {31'd0, InstrValid}, 32'd1);
            chk("stall_instr", Instr, 32'hC0 ^ 32'hA5);
            chk("stall_instrpc", InstrPC, 32'hC0);
            chk("stall_pc", PC, 32'hC4);
            chk("stall_req", {31'd0, IMemReq}, 32'd0);
            $display("stall cycle %0d instr=%h", i, Instr);
        end
        IMemAck = 1'b0;
        Stall   = 1'b0;
        consume(32'hC4);

        // 6: wrap at the top of the address space
        Jump       = 1'b1;
        JumpTarget = 32'hFFFF_FFFC;
        IMemAck    = 1'b1;
        cyc();
        Jump    = 1'b0;
        IMemAck = 1'b0;
        chk("top_addr", IMemAddr, 32'hFFFF_FFFC);
        fetch_ok(32'hFFFF_FFFC);
        chk("wrap_pc", PC, 32'h0);
        consume(32'h0);
        fetch_ok(32'h0);
        consume(32'h4);

        // 6b: asynchronous reset mid-REQ, then a late ack is ignored
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, IMemReq}, 32'd0);
        chk("arst_pc", PC, 32'h0);
        chk("arst_addr", IMemAddr, 32'h0);
        $display("async reset mid-REQ req=%b pc=%h", IMemReq, PC);
        cyc();
        IMemAck   = 1'b1;
        IMemRdata = 32'hBAD0_BAD0;
        cyc();
        chk("late_ack_valid", {31'd0, InstrValid}, 32'd0);
        chk("late_ack_req", {31'd0, IMemReq}, 32'd0);
        Rst_n = 1'b1;
        cyc();
        IMemAck = 1'b0;
        chk("reboot_valid", {31'd0, InstrValid}, 32'd0);
        fetch_ok(32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
